// File: rtl/autoconfig_host_if.sv
// Nibble-wide bus-master port between the AutoConfig host and the Z2 bus engine.
interface autoconfig_host_if;
  logic        bus_req;
  logic        bus_rw;
  logic [22:0] bus_addr;
  logic [3:0]  bus_dout;
  logic [3:0]  bus_din;
  logic        bus_ack;

  modport master (
    output bus_req, bus_rw, bus_addr, bus_dout,
    input  bus_din, bus_ack
  );

  modport slave (
    input  bus_req, bus_rw, bus_addr, bus_dout,
    output bus_din, bus_ack
  );
endinterface

// File: rtl/autoconfig_host.sv
// Zorro II AutoConfig host: walks the board chain at $E80000, reads each board's
// type byte, assigns it a base address in the RAM or I/O pool, or shuts it up.
module autoconfig_host #(
  parameter int MAX_BOARDS = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              cfg_n,
  autoconfig_host_if.master bus,
  output logic [7:0]        ram_top,
  output logic [7:0]        io_top,
  output logic [3:0]        num_cfg,
  output logic [3:0]        num_shutup
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_RD_HI  = 4'd1;
  localparam logic [3:0] S_RD_LO  = 4'd2;
  localparam logic [3:0] S_ALLOC  = 4'd3;
  localparam logic [3:0] S_WR_LO  = 4'd4;
  localparam logic [3:0] S_WR_HI  = 4'd5;
  localparam logic [3:0] S_SHUTUP = 4'd6;
  localparam logic [3:0] S_NEXT   = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  // Word addresses (A23:1) of the AutoConfig registers used here
  localparam logic [22:0] A_TYPE_HI = 23'h740000;  // $E80000
  localparam logic [22:0] A_TYPE_LO = 23'h740001;  // $E80002
  localparam logic [22:0] A_BASE_HI = 23'h740024;  // $E80048
  localparam logic [22:0] A_BASE_LO = 23'h740025;  // $E8004A
  localparam logic [22:0] A_SHUTUP  = 23'h740026;  // $E8004C

  logic [3:0]  state;
  logic [7:0]  board_type;
  logic [7:0]  base_reg;
  logic [8:0]  size_reg;
  logic        pool_ram;
  logic [7:0]  tmo_cnt;
  logic [3:0]  board_cnt;

  logic [22:0] cyc_addr;
  logic        cyc_rw;
  logic [3:0]  cyc_dout;

  logic        a_board;
  logic        a_ram;
  logic        a_fit;
  logic [8:0]  a_size;
  logic [8:0]  a_top;
  logic [8:0]  a_limit;
  logic [8:0]  a_base;
  logic [8:0]  new_top;

  assign busy    = (state != S_IDLE) && (state != S_DONE);
  assign done    = (state == S_DONE);
  assign cfg_n   = ~busy;
  assign new_top = {1'b0, base_reg} + size_reg;

  // Address, direction and write data of the cycle owned by the current state
  always_comb begin
    cyc_addr = A_TYPE_HI;
    cyc_rw   = 1'b1;
    cyc_dout = 4'h0;
    case (state)
      S_RD_LO:  cyc_addr = A_TYPE_LO;
      S_WR_LO:  begin cyc_addr = A_BASE_LO; cyc_rw = 1'b0; cyc_dout = base_reg[3:0]; end
      S_WR_HI:  begin cyc_addr = A_BASE_HI; cyc_rw = 1'b0; cyc_dout = base_reg[7:4]; end
      S_SHUTUP: begin cyc_addr = A_SHUTUP;  cyc_rw = 1'b0; end
      default:  ;
    endcase
  end

  // Placement: round the pool top up to the board size and test it against the pool limit
  always_comb begin
    a_board = (board_type[7:6] == 2'b11);
    a_ram   = board_type[5];
    a_size  = (board_type[2:0] == 3'd0) ? 9'd128 : (9'd1 << (board_type[2:0] - 3'd1));
    a_top   = {1'b0, (a_ram ? ram_top : io_top)};
    a_limit = a_ram ? 9'h0A0 : 9'h0F0;
    a_base  = (a_top + a_size - 9'd1) & ~(a_size - 9'd1);
    a_fit   = (a_base + a_size) <= a_limit;
    if (board_type[2:0] == 3'd0) begin
      a_base = a_top;
      a_fit  = a_ram && (ram_top == 8'h20);
    end
  end

  // Enumeration state machine and bus-master handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      bus.bus_req  <= 1'b0;
      bus.bus_rw   <= 1'b1;
      bus.bus_addr <= 23'h0;
      bus.bus_dout <= 4'h0;
      ram_top      <= 8'h20;
      io_top       <= 8'hE9;
      num_cfg      <= 4'h0;
      num_shutup   <= 4'h0;
      board_type   <= 8'h0;
      base_reg     <= 8'h0;
      size_reg     <= 9'h0;
      pool_ram     <= 1'b0;
      tmo_cnt      <= 8'h0;
      board_cnt    <= 4'h0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_RD_HI;
            ram_top    <= 8'h20;
            io_top     <= 8'hE9;
            num_cfg    <= 4'h0;
            num_shutup <= 4'h0;
            board_cnt  <= 4'h0;
          end
        end
        S_RD_HI, S_RD_LO, S_WR_LO, S_WR_HI, S_SHUTUP: begin
          if (!bus.bus_req) begin
            bus.bus_req  <= 1'b1;
            bus.bus_rw   <= cyc_rw;
            bus.bus_addr <= cyc_addr;
            bus.bus_dout <= cyc_dout;
            tmo_cnt      <= 8'h0;
          end else if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            case (state)
              S_RD_HI: begin board_type[7:4] <= bus.bus_din; state <= S_RD_LO; end
              S_RD_LO: begin board_type[3:0] <= bus.bus_din; state <= S_ALLOC; end
              S_WR_LO: state <= S_WR_HI;
              S_WR_HI: begin
                if (pool_ram) ram_top <= new_top[7:0];
                else          io_top  <= new_top[7:0];
                if (num_cfg != 4'hF) num_cfg <= num_cfg + 4'd1;
                board_cnt <= board_cnt + 4'd1;
                state     <= S_NEXT;
              end
              default: begin
                if (num_shutup != 4'hF) num_shutup <= num_shutup + 4'd1;
                board_cnt <= board_cnt + 4'd1;
                state     <= S_NEXT;
              end
            endcase
          end else if (tmo_cnt == 8'(TIMEOUT)) begin
            bus.bus_req <= 1'b0;
            state       <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_ALLOC: begin
          base_reg <= a_base[7:0];
          size_reg <= a_size;
          pool_ram <= a_ram;
          if (!a_board)   state <= S_DONE;
          else if (a_fit) state <= S_WR_LO;
          else            state <= S_SHUTUP;
        end
        S_NEXT: begin
          if (board_cnt >= 4'(MAX_BOARDS)) state <= S_DONE;
          else                             state <= S_RD_HI;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_autoconfig_host.sv
// Bench for autoconfig_host: a behavioural board chain answers bus cycles and a
// placement model derives the expected writes, pool tops and counters.
module tb_autoconfig_host;
  localparam int MAXB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, cfg_n;
  logic [7:0] ram_top, io_top;
  logic [3:0] num_cfg, num_shutup;

  autoconfig_host_if bus();

  autoconfig_host #(.MAX_BOARDS(MAXB), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .cfg_n(cfg_n),
    .bus(bus), .ram_top(ram_top), .io_top(io_top),
    .num_cfg(num_cfg), .num_shutup(num_shutup)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  board_q[$];
  int          board_idx = 0;
  logic [27:0] wr_log[$];
  logic [23:0] stall_addr;
  int          resp_delay = -1;
  logic [23:0] resp_addr;
  logic [7:0]  resp_type;

  int          exp_ram, exp_io, exp_cfg, exp_shut;
  logic [27:0] exp_log[$];

  logic        prev_req = 1'b0;
  logic [27:0] prev_cyc;

  always #5 clk = ~clk;

  // Board chain: answers type reads from the current board, logs writes, and
  // moves to the next board once it has been configured or shut up
  always @(negedge clk) begin
    bus.bus_ack = 1'b0;
    if (rst || !bus.bus_req) begin
      resp_delay = -1;
    end else begin
      resp_addr = {bus.bus_addr, 1'b0};
      if (resp_addr == stall_addr) begin
        resp_delay = -1;
      end else if (bus.bus_rw && board_idx >= board_q.size()) begin
        resp_delay = -1;
      end else begin
        if (resp_delay < 0) resp_delay = int'($urandom_range(0, 3));
        if (resp_delay == 0) begin
          bus.bus_ack = 1'b1;
          resp_delay  = -1;
          if (bus.bus_rw) begin
            resp_type   = board_q[board_idx];
            bus.bus_din = (resp_addr == 24'hE80000) ? resp_type[7:4] :
                          (resp_addr == 24'hE80002) ? resp_type[3:0] : 4'h0;
          end else begin
            wr_log.push_back({resp_addr, bus.bus_dout});
            if (resp_addr == 24'hE80048 || resp_addr == 24'hE8004C) board_idx++;
          end
        end else begin
          resp_delay--;
        end
      end
    end
  end

  // Status flag consistency and request stability while a cycle is pending
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((done && busy) || (cfg_n !== !busy)) begin
        errors++;
        $display("[TB] FAIL flags: busy=%b done=%b cfg_n=%b", busy, done, cfg_n);
      end
      if (prev_req && bus.bus_req) begin
        checks++;
        if ({bus.bus_addr, bus.bus_rw, bus.bus_dout} !== prev_cyc) begin
          errors++;
          $display("[TB] FAIL stable: cycle %h now, was %h", {bus.bus_addr, bus.bus_rw, bus.bus_dout}, prev_cyc);
        end
      end
    end
    prev_req = bus.bus_req;
    prev_cyc = {bus.bus_addr, bus.bus_rw, bus.bus_dout};
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Placement model: walk the board list with plain integer arithmetic
  task automatic model_run();
    int ram, io, code, size, base, top, limit;
    bit fit;
    logic [7:0] t;
    ram = 32; io = 233; exp_cfg = 0; exp_shut = 0;
    exp_log.delete();
    for (int n = 0; n < MAXB && n < board_q.size(); n++) begin
      t = board_q[n];
      if (t[7:6] != 2'b11) break;
      code  = int'(t[2:0]);
      size  = (code == 0) ? 128 : (1 << (code - 1));
      top   = t[5] ? ram : io;
      limit = t[5] ? 160 : 240;
      if (size == 128) begin
        base = 32;
        fit  = t[5] && (ram == 32);
      end else begin
        base = ((top + size - 1) / size) * size;
        fit  = (base + size) <= limit;
      end
      if (fit) begin
        exp_log.push_back({24'hE8004A, 4'(base % 16)});
        exp_log.push_back({24'hE80048, 4'(base / 16)});
        if (t[5]) ram = base + size;
        else      io  = base + size;
        exp_cfg++;
      end else begin
        exp_log.push_back({24'hE8004C, 4'h0});
        exp_shut++;
      end
    end
    exp_ram = ram;
    exp_io  = io;
  endtask

  task automatic run_enum(output int cycles, output bit finished);
    board_idx = 0;
    wr_log.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cycles = 1;
    while (!done && cycles < 5000) begin
      @(negedge clk);
      cycles++;
    end
    finished = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, cfg_n, bus.bus_req, bus.bus_rw} !== 5'b00101) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: busy/done/cfg_n/req/rw=%b want 00101", {busy, done, cfg_n, bus.bus_req, bus.bus_rw});
    end
    checks++;
    if ({bus.bus_addr, bus.bus_dout} !== 27'h0) begin
      errors++;
      $display("[TB] FAIL reset_bus: addr=%h dout=%h want 0", bus.bus_addr, bus.bus_dout);
    end
    checks++;
    if ({ram_top, io_top, num_cfg, num_shutup} !== 24'h20E900) begin
      errors++;
      $display("[TB] FAIL reset_tops: %h want 20e900", {ram_top, io_top, num_cfg, num_shutup});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int cyc;
    bit fin;
    board_q.delete();
    run_enum(cyc, fin);
    checks++;
    if (!fin || cyc < 255 || cyc > 270) begin
      errors++;
      $display("[TB] FAIL timeout_latency: done=%b after %0d cycles, want done within 255..270", fin, cyc);
    end
    checks++;
    if ({num_cfg, num_shutup, bus.bus_req, busy} !== 10'b0) begin
      errors++;
      $display("[TB] FAIL timeout_state: cfg=%0d shut=%0d req=%b busy=%b want all 0", num_cfg, num_shutup, bus.bus_req, busy);
    end
  endtask

  task automatic test_allocation();
    int cyc;
    bit fin;
    for (int c = 0; c < 10; c++) begin
      board_q.delete();
      case (c)
        0: board_q.push_back(8'hE0);
        1: begin board_q.push_back(8'hE6); board_q.push_back(8'hE7); end
        2: begin board_q.push_back(8'hE6); board_q.push_back(8'hE0); end
        3: board_q.push_back(8'hC1);
        default: begin
          for (int k = 0; k < int'($urandom_range(1, 9)); k++)
            board_q.push_back(($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 191))
                                                          : {2'b11, 6'($urandom)});
        end
      endcase
      model_run();
      run_enum(cyc, fin);
      checks++;
      if (!fin) begin
        errors++;
        $display("[TB] FAIL alloc%0d_done: done never rose within 5000 cycles", c);
      end
      checks++;
      if (ram_top !== 8'(exp_ram) || io_top !== 8'(exp_io)) begin
        errors++;
        $display("[TB] FAIL alloc%0d_tops: ram=%h io=%h want ram=%h io=%h", c, ram_top, io_top, 8'(exp_ram), 8'(exp_io));
      end
      checks++;
      if (num_cfg !== 4'(exp_cfg) || num_shutup !== 4'(exp_shut)) begin
        errors++;
        $display("[TB] FAIL alloc%0d_counts: cfg=%0d shut=%0d want cfg=%0d shut=%0d", c, num_cfg, num_shutup, exp_cfg, exp_shut);
      end
      checks++;
      if (wr_log.size() != exp_log.size()) begin
        errors++;
        $display("[TB] FAIL alloc%0d_nwrites: %0d writes want %0d", c, wr_log.size(), exp_log.size());
      end else begin
        foreach (exp_log[i]) begin
          checks++;
          if (wr_log[i] !== exp_log[i]) begin
            errors++;
            $display("[TB] FAIL alloc%0d_write%0d: addr/data %h want %h", c, i, wr_log[i], exp_log[i]);
          end
        end
      end
      checks++;
      if (bus.bus_req !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL alloc%0d_idle: req=%b busy=%b want 0 0", c, bus.bus_req, busy);
      end
    end
  endtask

  task automatic test_max_boards();
    int cyc;
    bit fin;
    board_q.delete();
    repeat (9) board_q.push_back(8'hC1);
    run_enum(cyc, fin);
    checks++;
    if (!fin || num_cfg !== 4'd7 || num_shutup !== 4'd1) begin
      errors++;
      $display("[TB] FAIL max_counts: done=%b cfg=%0d shut=%0d want 1 7 1", fin, num_cfg, num_shutup);
    end
    checks++;
    if (board_idx != 8 || io_top !== 8'hF0) begin
      errors++;
      $display("[TB] FAIL max_stop: boards visited=%0d io_top=%h want 8 f0", board_idx, io_top);
    end
  endtask

  task automatic test_reset_mid_write();
    int cyc;
    board_q.delete();
    board_q.push_back(8'hE6);
    board_idx = 0;
    stall_addr = 24'hE80048;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (!(bus.bus_req && bus.bus_addr == 23'h740024) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 200) begin
      errors++;
      $display("[TB] FAIL rst_mid_reach: WR_HI request not seen within %0d cycles", cyc);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done, cfg_n, bus.bus_req, bus.bus_rw} !== 5'b00101 || {bus.bus_addr, bus.bus_dout} !== 27'h0) begin
      errors++;
      $display("[TB] FAIL rst_mid_bus: ctrl=%b addr=%h dout=%h want 00101 0 0", {busy, done, cfg_n, bus.bus_req, bus.bus_rw}, bus.bus_addr, bus.bus_dout);
    end
    checks++;
    if ({ram_top, io_top, num_cfg, num_shutup} !== 24'h20E900) begin
      errors++;
      $display("[TB] FAIL rst_mid_tops: %h want 20e900", {ram_top, io_top, num_cfg, num_shutup});
    end
    @(negedge clk);
    rst = 1'b0;
    stall_addr = 24'hFFFFFF;
    @(negedge clk);
  endtask

  // Scenario sequence
  initial begin
    rst = 1'b1;
    start = 1'b0;
    stall_addr = 24'hFFFFFF;
    bus.bus_ack = 1'b0;
    bus.bus_din = 4'h0;
    test_reset();
    test_timeout();
    test_allocation();
    test_max_boards();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
